// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among NUM_REQ execute units.
// An owner holds the ALU up to MAX_HOLD cycles while others wait, then gets preempted.
module alu_arbiter #(
   parameter int         NUM_REQ  = 4,
   parameter int         MAX_HOLD = 8,
   parameter logic [4:0] IDLE_OP  = 5'd8,
   localparam int        ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int        HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0][32:0] req_in_a,
   input  logic [NUM_REQ-1:0][32:0] req_in_b,
   input  logic [NUM_REQ-1:0][4:0]  req_alu_op,
   output logic [NUM_REQ-1:0]       grant,
   output logic [ID_W-1:0]          owner_id,
   output logic                     alu_valid,
   output logic [32:0]              in_a,
   output logic [32:0]              in_b,
   output logic [4:0]               alu_op,
   output logic                     preempt
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [ID_W-1:0]      r_owner;
   logic                 r_valid;
   logic                 r_preempt;
   logic [HOLD_W-1:0]    r_hold;
   logic [ID_W-1:0]      r_rr_ptr;

   logic [NUM_REQ-1:0]   w_cand;
   logic                 w_found;
   logic [ID_W-1:0]      w_win;
   logic [NUM_REQ-1:0]   w_win_oh;
   logic [ID_W-1:0]      w_next_ptr;
   logic                 w_own_req;
   logic                 w_hold_last;
   logic                 w_keep;

   // Descending scan so the last hit is the first candidate at or after ptr.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                             input logic [ID_W-1:0]    ptr);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (cand[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
      end
      return res;
   endfunction

   // The current owner is never a candidate, which also excludes a preempted owner.
   always_comb begin
      w_cand             = req & ~r_grant;
      {w_found, w_win}   = rr_pick(w_cand, r_rr_ptr);
      w_win_oh           = '0;
      w_win_oh[w_win]    = 1'b1;
      w_next_ptr         = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      w_own_req          = |(req & r_grant);
      w_hold_last        = (r_hold == HOLD_LAST);
      w_keep             = (r_state == S_BUSY) && w_own_req && !(w_hold_last && w_found);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_valid   <= 1'b0;
         r_preempt <= 1'b0;
         r_hold    <= '0;
         r_rr_ptr  <= '0;
      end else if (w_keep) begin
         r_preempt <= 1'b0;
         if (!w_hold_last) r_hold <= r_hold + 1'b1;
      end else if (w_found) begin
         // Handover on the same edge; a still-requesting owner means forced release.
         r_state   <= S_BUSY;
         r_grant   <= w_win_oh;
         r_owner   <= w_win;
         r_valid   <= 1'b1;
         r_preempt <= w_own_req;
         r_hold    <= '0;
         r_rr_ptr  <= w_next_ptr;
      end else begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_valid   <= 1'b0;
         r_preempt <= 1'b0;
         r_hold    <= '0;
      end
   end

   assign grant     = r_grant;
   assign owner_id  = r_owner;
   assign alu_valid = r_valid;
   assign preempt   = r_preempt;
   assign in_a      = r_valid ? req_in_a[r_owner]   : 33'd0;
   assign in_b      = r_valid ? req_in_b[r_owner]   : 33'd0;
   assign alu_op    = r_valid ? req_alu_op[r_owner] : IDLE_OP;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: vector table, directed hold/preempt sequences, random stream vs model.
module tb_alu_arbiter;
   localparam int NR       = 4;
   localparam int MAX_HOLD = 8;

   logic              clk;
   logic              reset;
   logic [NR-1:0]     req;
   logic [NR-1:0][32:0] a, b;
   logic [NR-1:0][4:0]  op;
   logic [NR-1:0]     grant;
   logic [1:0]        owner_id;
   logic              alu_valid;
   logic [32:0]       in_a, in_b;
   logic [4:0]        alu_op;
   logic              preempt;

   int n_tests = 0;
   int n_fail  = 0;

   alu_arbiter #(.NUM_REQ(NR), .MAX_HOLD(MAX_HOLD), .IDLE_OP(5'd8)) dut (
      .clk(clk), .reset(reset), .req(req),
      .req_in_a(a), .req_in_b(b), .req_alu_op(op),
      .grant(grant), .owner_id(owner_id), .alu_valid(alu_valid),
      .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .preempt(preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] rq;
      logic [3:0] g;
      logic       pre;
   } vec_t;

   vec_t tbl[16];

   // reference model state
   int   m_owner, m_hold, m_ptr;
   logic m_pre;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic ep);
      int         o;
      logic [32:0] ea, eb;
      logic [4:0]  eo;
      o = 0;
      for (int i = 0; i < NR; i++) if (((eg >> i) & 4'd1) != 0) o = i;
      if (eg != 4'd0) begin
         ea = a[2'(o)]; eb = b[2'(o)]; eo = op[2'(o)];
      end else begin
         ea = 33'd0; eb = 33'd0; eo = 5'd8;
      end
      chk({tag, ".grant"},   64'(grant),     64'(eg));
      chk({tag, ".owner"},   64'(owner_id),  64'(o));
      chk({tag, ".valid"},   64'(alu_valid), 64'(eg != 4'd0));
      chk({tag, ".preempt"}, 64'(preempt),   64'(ep));
      chk({tag, ".in_a"},    64'(in_a),      64'(ea));
      chk({tag, ".in_b"},    64'(in_b),      64'(eb));
      chk({tag, ".alu_op"},  64'(alu_op),    64'(eo));
      chk({tag, ".onehot0"}, 64'($onehot0(grant)), 64'd1);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      req   = '0;
      tick();
      check_all(tag, 4'd0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic model_step(input logic rst, input logic [3:0] r);
      logic [3:0] others;
      logic       own_req, forced;
      if (rst) begin
         m_owner = -1; m_hold = 0; m_ptr = 0; m_pre = 1'b0;
         return;
      end
      others  = (m_owner >= 0) ? (r & ~(4'd1 << m_owner)) : r;
      own_req = (m_owner >= 0) && (((r >> m_owner) & 4'd1) != 0);
      m_pre   = 1'b0;
      if (own_req && !(m_hold == MAX_HOLD - 1 && others != 4'd0)) begin
         if (m_hold < MAX_HOLD - 1) m_hold = m_hold + 1;
         return;
      end
      forced  = own_req;
      m_owner = -1;
      for (int k = 0; k < NR; k++) begin
         if (m_owner < 0 && (((others >> ((m_ptr + k) % NR)) & 4'd1) != 0))
            m_owner = (m_ptr + k) % NR;
      end
      if (m_owner >= 0) begin
         m_hold = 0;
         m_ptr  = (m_owner + 1) % NR;
         m_pre  = forced;
      end else begin
         m_hold = 0;
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      for (int i = 0; i < NR; i++) begin
         a[i]  = 33'h1_0000_0000 | 33'(i * 32'h1111);
         b[i]  = 33'(i * 3 + 7);
         op[i] = 5'(i + 1);
      end

      // reset, single holder, back-to-back handover, reset mid-grant
      tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0};
      tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 1'b0};
      tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 1'b0};
      tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0};
      tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
      tbl[6]  = '{1'b0, 4'b1111, 4'b0001, 1'b0};
      tbl[7]  = '{1'b0, 4'b1110, 4'b0010, 1'b0};
      tbl[8]  = '{1'b0, 4'b1100, 4'b0100, 1'b0};
      tbl[9]  = '{1'b0, 4'b1000, 4'b1000, 1'b0};
      tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0};
      tbl[11] = '{1'b0, 4'b0100, 4'b0100, 1'b0};
      tbl[12] = '{1'b1, 4'b0100, 4'b0000, 1'b0};
      tbl[13] = '{1'b0, 4'b0110, 4'b0010, 1'b0};
      tbl[14] = '{1'b0, 4'b0100, 4'b0100, 1'b0};
      tbl[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0};

      for (int v = 0; v < 16; v++) begin
         reset = tbl[v].rst;
         req   = tbl[v].rq;
         tick();
         check_all($sformatf("tbl%0d", v), tbl[v].g, tbl[v].pre);
      end
      reset = 1'b0;

      // request pulse that never survives to an edge
      do_reset("glitch.rst");
      #3 req = 4'b1000;
      #2 req = 4'b0000;
      tick();
      check_all("glitch", 4'b0000, 1'b0);

      // forced release after MAX_HOLD cycles, then re-grant of the preempted unit
      do_reset("pre.rst");
      req = 4'b0001;
      tick();
      check_all("pre.c1", 4'b0001, 1'b0);
      req = 4'b0101;
      for (int c = 2; c <= MAX_HOLD; c++) begin
         tick();
         check_all($sformatf("pre.c%0d", c), 4'b0001, 1'b0);
      end
      tick();
      check_all("pre.switch", 4'b0100, 1'b1);
      tick();
      check_all("pre.after", 4'b0100, 1'b0);
      req = 4'b0001;
      tick();
      check_all("pre.regrant", 4'b0001, 1'b0);

      // lone holder is never preempted
      do_reset("solo.rst");
      req = 4'b0001;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check_all($sformatf("solo.c%0d", c), 4'b0001, 1'b0);
      end

      // random level-held request stream against the model
      reset = 1'b1;
      req   = '0;
      model_step(reset, req);
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            a[i]  = {1'($urandom), 32'($urandom)};
            b[i]  = {1'($urandom), 32'($urandom)};
            op[i] = 5'($urandom);
         end
         model_step(reset, req);
         tick();
         check_all($sformatf("rnd%0d", cyc),
                   (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0, m_pre);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
